// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two bus masters (CPU, DMA), the arbiter and the shared slave bus.
// The arbiter connects through the slave modport; the master modport is the mirror view.
interface mem_bus_arbiter_if #(
  parameter int BITS         = 16,
  parameter int ADDRESS_BITS = 16,
  parameter int NUM_PERIPH   = 6
);
  logic                         CPU_REQ;
  logic [ADDRESS_BITS-1:0]      CPU_ADDRESS;
  logic [BITS-1:0]              CPU_DATA_IN;
  logic                         CPU_WRb;
  logic [BITS-1:0]              CPU_DATA_OUT;
  logic                         CPU_READY;
  logic                         CPU_ERR;

  logic                         DMA_REQ;
  logic [ADDRESS_BITS-1:0]      DMA_ADDRESS;
  logic [BITS-1:0]              DMA_DATA_IN;
  logic                         DMA_WRb;
  logic [BITS-1:0]              DMA_DATA_OUT;
  logic                         DMA_READY;
  logic                         DMA_ERR;

  logic [ADDRESS_BITS-1:0]      MEM_ADDRESS;
  logic [BITS-1:0]              MEM_DATA_OUT;
  logic                         MEM_WRb;
  logic                         ROM_SEL;
  logic                         OCM_SEL;
  logic                         HIRAM_SEL;
  logic [NUM_PERIPH-1:0]        PERIPH_SEL;
  logic [BITS-1:0]              ROM_DATA;
  logic [BITS-1:0]              OCM_DATA;
  logic [BITS-1:0]              HIRAM_DATA;
  logic [NUM_PERIPH*BITS-1:0]   PERIPH_DATA;

  modport slave (
    input  CPU_REQ, CPU_ADDRESS, CPU_DATA_IN, CPU_WRb,
    output CPU_DATA_OUT, CPU_READY, CPU_ERR,
    input  DMA_REQ, DMA_ADDRESS, DMA_DATA_IN, DMA_WRb,
    output DMA_DATA_OUT, DMA_READY, DMA_ERR,
    output MEM_ADDRESS, MEM_DATA_OUT, MEM_WRb,
    output ROM_SEL, OCM_SEL, HIRAM_SEL, PERIPH_SEL,
    input  ROM_DATA, OCM_DATA, HIRAM_DATA, PERIPH_DATA
  );

  modport master (
    output CPU_REQ, CPU_ADDRESS, CPU_DATA_IN, CPU_WRb,
    input  CPU_DATA_OUT, CPU_READY, CPU_ERR,
    output DMA_REQ, DMA_ADDRESS, DMA_DATA_IN, DMA_WRb,
    input  DMA_DATA_OUT, DMA_READY, DMA_ERR,
    input  MEM_ADDRESS, MEM_DATA_OUT, MEM_WRb,
    input  ROM_SEL, OCM_SEL, HIRAM_SEL, PERIPH_SEL,
    output ROM_DATA, OCM_DATA, HIRAM_DATA, PERIPH_DATA
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master (CPU, DMA) round-robin arbiter with registered address decode, per-region
// wait states and a one-cycle READY/ERR completion pulse.
module mem_bus_arbiter #(
  parameter int BITS         = 16,
  parameter int ADDRESS_BITS = 16,
  parameter int NUM_PERIPH   = 6,
  parameter int ROM_WAIT     = 0,
  parameter int PERIPH_WAIT  = 1,
  parameter int OCM_WAIT     = 0,
  parameter int HIRAM_WAIT   = 0
) (
  input  logic             CLK,
  input  logic             RSTb,
  mem_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic [2:0] {R_NONE, R_ROM, R_PERIPH, R_OCM, R_HIRAM} region_t;

  state_t                  state_reg, state_next;
  logic                    grant_dma_reg, grant_dma_next;
  logic                    last_dma_reg, last_dma_next;
  logic [ADDRESS_BITS-1:0] addr_reg, addr_next;
  logic [BITS-1:0]         wdata_reg, wdata_next;
  logic                    wrb_reg, wrb_next;
  region_t                 region_reg, region_next;
  logic [3:0]              slot_reg, slot_next;
  logic [3:0]              wait_reg, wait_next;
  logic [BITS-1:0]         cpu_dout_reg, cpu_dout_next;
  logic [BITS-1:0]         dma_dout_reg, dma_dout_next;

  logic                    pick_dma;
  logic [ADDRESS_BITS-1:0] req_addr;
  region_t                 req_region;
  logic [BITS-1:0]         rdata;
  logic [BITS-1:0]         periph_rdata;
  logic [BITS-1:0]         periph_masked [NUM_PERIPH];
  logic                    in_access;
  logic                    strobe_cycle;
  logic                    in_done;

  // The address map is defined on the low 16 address bits.
  function automatic region_t decode_region(input logic [15:0] a, input logic from_dma);
    region_t r;
    r = R_NONE;
    if (a[15])
      r = R_HIRAM;
    else if (a[15:14] == 2'b01)
      r = R_OCM;
    else if (a[15:12] == 4'h0)
      r = R_ROM;
    else if (a[15:12] == 4'h1 && {1'b0, a[11:8]} < 5'(NUM_PERIPH))
      r = R_PERIPH;
    // The DMA engine may only reach on-chip memory.
    if (from_dma && r != R_OCM)
      r = R_NONE;
    return r;
  endfunction

  function automatic logic [3:0] region_wait(input region_t r);
    logic [3:0] w;
    case (r)
      R_ROM:    w = 4'(ROM_WAIT);
      R_PERIPH: w = 4'(PERIPH_WAIT);
      R_OCM:    w = 4'(OCM_WAIT);
      R_HIRAM:  w = 4'(HIRAM_WAIT);
      default:  w = 4'd0;
    endcase
    return w;
  endfunction

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state_reg     <= IDLE;
      grant_dma_reg <= 1'b0;
      last_dma_reg  <= 1'b1;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      wrb_reg       <= 1'b1;
      region_reg    <= R_NONE;
      slot_reg      <= 4'd0;
      wait_reg      <= 4'd0;
      cpu_dout_reg  <= '0;
      dma_dout_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      grant_dma_reg <= grant_dma_next;
      last_dma_reg  <= last_dma_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      wrb_reg       <= wrb_next;
      region_reg    <= region_next;
      slot_reg      <= slot_next;
      wait_reg      <= wait_next;
      cpu_dout_reg  <= cpu_dout_next;
      dma_dout_reg  <= dma_dout_next;
    end
  end

  // DMA wins only when it is alone or the CPU had the previous grant.
  always_comb begin
    pick_dma   = bus.DMA_REQ && (!bus.CPU_REQ || !last_dma_reg);
    req_addr   = pick_dma ? bus.DMA_ADDRESS : bus.CPU_ADDRESS;
    req_region = decode_region(req_addr[15:0], pick_dma);
  end

  always_comb begin
    state_next     = state_reg;
    grant_dma_next = grant_dma_reg;
    last_dma_next  = last_dma_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    wrb_next       = wrb_reg;
    region_next    = region_reg;
    slot_next      = slot_reg;
    wait_next      = wait_reg;
    cpu_dout_next  = cpu_dout_reg;
    dma_dout_next  = dma_dout_reg;
    case (state_reg)
      IDLE: begin
        if (bus.CPU_REQ || bus.DMA_REQ) begin
          grant_dma_next = pick_dma;
          last_dma_next  = pick_dma;
          addr_next      = req_addr;
          wdata_next     = pick_dma ? bus.DMA_DATA_IN : bus.CPU_DATA_IN;
          wrb_next       = pick_dma ? bus.DMA_WRb : bus.CPU_WRb;
          region_next    = req_region;
          slot_next      = req_addr[11:8];
          wait_next      = region_wait(req_region);
          state_next     = ACCESS;
        end
      end
      ACCESS: begin
        if (wait_reg != 4'd0) begin
          wait_next = wait_reg - 4'd1;
        end else begin
          state_next = DONE;
          if (wrb_reg) begin
            if (grant_dma_reg)
              dma_dout_next = rdata;
            else
              cpu_dout_next = rdata;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PERIPH; gi++) begin : g_periph
      assign periph_masked[gi]  = (slot_reg == 4'(gi)) ? bus.PERIPH_DATA[gi*BITS +: BITS] : '0;
      assign bus.PERIPH_SEL[gi] = in_access && (region_reg == R_PERIPH) && (slot_reg == 4'(gi));
    end
  endgenerate

  always_comb begin
    periph_rdata = '0;
    for (int i = 0; i < NUM_PERIPH; i++)
      periph_rdata = periph_rdata | periph_masked[i];
  end

  always_comb begin
    case (region_reg)
      R_ROM:    rdata = bus.ROM_DATA;
      R_PERIPH: rdata = periph_rdata;
      R_OCM:    rdata = bus.OCM_DATA;
      R_HIRAM:  rdata = bus.HIRAM_DATA;
      default:  rdata = '0;
    endcase
  end

  assign in_access    = (state_reg == ACCESS);
  assign in_done      = (state_reg == DONE);
  assign strobe_cycle = in_access && (wait_reg == 4'd0);

  assign bus.ROM_SEL      = in_access && (region_reg == R_ROM);
  assign bus.OCM_SEL      = in_access && (region_reg == R_OCM);
  assign bus.HIRAM_SEL    = in_access && (region_reg == R_HIRAM);
  assign bus.MEM_WRb      = !(strobe_cycle && !wrb_reg && (region_reg != R_NONE));
  assign bus.MEM_ADDRESS  = addr_reg;
  assign bus.MEM_DATA_OUT = wdata_reg;

  assign bus.CPU_READY    = in_done && !grant_dma_reg;
  assign bus.CPU_ERR      = in_done && !grant_dma_reg && (region_reg == R_NONE);
  assign bus.DMA_READY    = in_done && grant_dma_reg;
  assign bus.DMA_ERR      = in_done && grant_dma_reg && (region_reg == R_NONE);
  assign bus.CPU_DATA_OUT = cpu_dout_reg;
  assign bus.DMA_DATA_OUT = dma_dout_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: table of single transactions through a scoreboard,
// then reset-abort, round-robin contention and back-to-back sequences.
module tb_mem_bus_arbiter;

  logic CLK;
  logic RSTb;

  mem_bus_arbiter_if #(.BITS(16), .ADDRESS_BITS(16), .NUM_PERIPH(6)) bus ();

  mem_bus_arbiter #(
    .BITS(16), .ADDRESS_BITS(16), .NUM_PERIPH(6),
    .ROM_WAIT(0), .PERIPH_WAIT(1), .OCM_WAIT(0), .HIRAM_WAIT(3)
  ) dut (
    .CLK  (CLK),
    .RSTb (RSTb),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        is_dma;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        wrb;
    int          exp_lat;
    logic [15:0] exp_dout;
    logic        exp_err;
    logic [8:0]  exp_sel;     // {ROM, OCM, HIRAM, PERIPH[5:0]}
    int          exp_sel_cyc;
    int          exp_strobes;
  } vec_t;

  localparam logic [8:0] S_NONE  = 9'b000_000000;
  localparam logic [8:0] S_ROM   = 9'b100_000000;
  localparam logic [8:0] S_OCM   = 9'b010_000000;
  localparam logic [8:0] S_HIRAM = 9'b001_000000;
  localparam logic [8:0] S_P0    = 9'b000_000001;
  localparam logic [8:0] S_P5    = 9'b000_100000;

  int          checks = 0;
  int          errors = 0;
  vec_t        vecs [18];
  vec_t        sb_q [$];
  logic [15:0] cpu_shadow = '0;
  logic [15:0] dma_shadow = '0;
  int          nev;
  int          k;
  int          cnt_a;
  int          cnt_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic dma, input logic [15:0] a, input logic [15:0] d,
                              input logic wrb, input int lat, input logic [15:0] dout,
                              input logic err, input logic [8:0] sel, input int sel_cyc,
                              input int strobes);
    vec_t v;
    v.is_dma = dma; v.addr = a; v.wdata = d; v.wrb = wrb;
    v.exp_lat = lat; v.exp_dout = dout; v.exp_err = err;
    v.exp_sel = sel; v.exp_sel_cyc = sel_cyc; v.exp_strobes = strobes;
    return v;
  endfunction

  function automatic logic [8:0] cur_sel();
    return {bus.ROM_SEL, bus.OCM_SEL, bus.HIRAM_SEL, bus.PERIPH_SEL};
  endfunction

  task automatic run_txn(input vec_t v, input int idx);
    vec_t        e;
    int          cyc, sel_cyc, strobes;
    logic [8:0]  sel_or;
    logic        seen, other_seen, err;
    logic [15:0] dout, other_dout;
    cyc = 0; sel_cyc = 0; strobes = 0; sel_or = '0;
    seen = 1'b0; other_seen = 1'b0; err = 1'b0; dout = '0; other_dout = '0;
    @(negedge CLK);
    if (v.is_dma) begin
      bus.DMA_REQ = 1'b1; bus.DMA_ADDRESS = v.addr; bus.DMA_DATA_IN = v.wdata; bus.DMA_WRb = v.wrb;
    end else begin
      bus.CPU_REQ = 1'b1; bus.CPU_ADDRESS = v.addr; bus.CPU_DATA_IN = v.wdata; bus.CPU_WRb = v.wrb;
    end
    sb_q.push_back(v);
    while (!seen && cyc < 40) begin
      @(posedge CLK); #1;
      cyc++;
      if (cur_sel() != 9'd0) begin
        sel_cyc++;
        sel_or = sel_or | cur_sel();
      end
      if (bus.MEM_WRb == 1'b0) begin
        strobes++;
        check("mem_addr", 32'(bus.MEM_ADDRESS), 32'(v.addr));
        check("mem_wdata", 32'(bus.MEM_DATA_OUT), 32'(v.wdata));
      end
      if (v.is_dma) begin
        seen = bus.DMA_READY; err = bus.DMA_ERR; dout = bus.DMA_DATA_OUT;
        other_seen = other_seen | bus.CPU_READY | bus.CPU_ERR; other_dout = bus.CPU_DATA_OUT;
      end else begin
        seen = bus.CPU_READY; err = bus.CPU_ERR; dout = bus.CPU_DATA_OUT;
        other_seen = other_seen | bus.DMA_READY | bus.DMA_ERR; other_dout = bus.DMA_DATA_OUT;
      end
    end
    bus.CPU_REQ = 1'b0;
    bus.DMA_REQ = 1'b0;
    e = sb_q.pop_front();
    check("ready_seen", 32'(seen), 32'd1);
    check("latency", 32'(cyc), 32'(e.exp_lat));
    check("data_out", 32'(dout), 32'(e.exp_dout));
    check("err", 32'(err), 32'(e.exp_err));
    check("sel_which", 32'(sel_or), 32'(e.exp_sel));
    check("sel_cycles", 32'(sel_cyc), 32'(e.exp_sel_cyc));
    check("wr_strobes", 32'(strobes), 32'(e.exp_strobes));
    check("other_quiet", 32'(other_seen), 32'd0);
    check("other_dout", 32'(other_dout), 32'(e.is_dma ? cpu_shadow : dma_shadow));
    if (e.is_dma) dma_shadow = e.exp_dout;
    else          cpu_shadow = e.exp_dout;
    $display("txn %0d %s %s addr=%04h lat=%0d dout=%04h err=%0b", idx, e.is_dma ? "DMA" : "CPU",
             e.wrb ? "RD" : "WR", e.addr, cyc, dout, err);
    @(posedge CLK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    RSTb = 1'b0;
    bus.CPU_REQ = 1'b0; bus.CPU_ADDRESS = '0; bus.CPU_DATA_IN = '0; bus.CPU_WRb = 1'b1;
    bus.DMA_REQ = 1'b0; bus.DMA_ADDRESS = '0; bus.DMA_DATA_IN = '0; bus.DMA_WRb = 1'b1;
    bus.ROM_DATA = 16'hBEEF; bus.OCM_DATA = 16'h0C0C; bus.HIRAM_DATA = 16'h4A4A;
    for (int i = 0; i < 6; i++) bus.PERIPH_DATA[i*16 +: 16] = 16'h5100 + 16'(i);

    repeat (2) @(posedge CLK);
    #1;
    check("rst_sel", 32'(cur_sel()), 32'd0);
    check("rst_wrb", 32'(bus.MEM_WRb), 32'd1);
    check("rst_addr", 32'(bus.MEM_ADDRESS), 32'd0);
    check("rst_wdata", 32'(bus.MEM_DATA_OUT), 32'd0);
    check("rst_ready", 32'({bus.CPU_READY, bus.CPU_ERR, bus.DMA_READY, bus.DMA_ERR}), 32'd0);
    check("rst_dout", 32'({bus.CPU_DATA_OUT, bus.DMA_DATA_OUT}), 32'd0);
    @(negedge CLK);
    RSTb = 1'b1;
    @(posedge CLK);

    //          dma   addr      wdata     wrb  lat dout      err  sel      scyc strobes
    vecs[0]  = mk(1'b0, 16'h0005, 16'h0000, 1'b1, 2, 16'hBEEF, 1'b0, S_ROM,   1, 0);
    vecs[1]  = mk(1'b0, 16'h1000, 16'h0041, 1'b0, 3, 16'hBEEF, 1'b0, S_P0,    2, 1);
    vecs[2]  = mk(1'b0, 16'h1520, 16'h0000, 1'b1, 3, 16'h5105, 1'b0, S_P5,    2, 0);
    vecs[3]  = mk(1'b0, 16'h1600, 16'h0000, 1'b1, 2, 16'h0000, 1'b1, S_NONE,  0, 0);
    vecs[4]  = mk(1'b0, 16'h0FFF, 16'h0000, 1'b1, 2, 16'hBEEF, 1'b0, S_ROM,   1, 0);
    vecs[5]  = mk(1'b0, 16'h2000, 16'h0000, 1'b1, 2, 16'h0000, 1'b1, S_NONE,  0, 0);
    vecs[6]  = mk(1'b0, 16'h2000, 16'h1234, 1'b0, 2, 16'h0000, 1'b1, S_NONE,  0, 0);
    vecs[7]  = mk(1'b0, 16'h4000, 16'h0000, 1'b1, 2, 16'h0C0C, 1'b0, S_OCM,   1, 0);
    vecs[8]  = mk(1'b0, 16'h3FFF, 16'h0000, 1'b1, 2, 16'h0000, 1'b1, S_NONE,  0, 0);
    vecs[9]  = mk(1'b0, 16'h7FFF, 16'h0000, 1'b1, 2, 16'h0C0C, 1'b0, S_OCM,   1, 0);
    vecs[10] = mk(1'b0, 16'h8000, 16'h0000, 1'b1, 5, 16'h4A4A, 1'b0, S_HIRAM, 4, 0);
    vecs[11] = mk(1'b0, 16'hFFFE, 16'h7777, 1'b0, 5, 16'h4A4A, 1'b0, S_HIRAM, 4, 1);
    vecs[12] = mk(1'b1, 16'h4001, 16'h0000, 1'b1, 2, 16'h0C0C, 1'b0, S_OCM,   1, 0);
    vecs[13] = mk(1'b1, 16'h8000, 16'h0000, 1'b1, 2, 16'h0000, 1'b1, S_NONE,  0, 0);
    vecs[14] = mk(1'b1, 16'h4001, 16'h0000, 1'b1, 2, 16'h0C0C, 1'b0, S_OCM,   1, 0);
    vecs[15] = mk(1'b1, 16'h4010, 16'hCAFE, 1'b0, 2, 16'h0C0C, 1'b0, S_OCM,   1, 1);
    vecs[16] = mk(1'b1, 16'h0005, 16'h0000, 1'b1, 2, 16'h0000, 1'b1, S_NONE,  0, 0);
    vecs[17] = mk(1'b1, 16'h1000, 16'h0055, 1'b0, 2, 16'h0000, 1'b1, S_NONE,  0, 0);

    for (int i = 0; i < 18; i++) run_txn(vecs[i], i);

    // Reset pulse in the middle of a HIRAM access (three wait states).
    @(negedge CLK);
    bus.CPU_REQ = 1'b1; bus.CPU_ADDRESS = 16'h8000; bus.CPU_WRb = 1'b1;
    @(posedge CLK); #1;
    check("abort_sel_before", 32'(bus.HIRAM_SEL), 32'd1);
    #2 RSTb = 1'b0;
    #1;
    check("abort_sel_after", 32'(cur_sel()), 32'd0);
    check("abort_ready", 32'(bus.CPU_READY), 32'd0);
    check("abort_dout", 32'(bus.CPU_DATA_OUT), 32'd0);
    check("abort_wrb", 32'(bus.MEM_WRb), 32'd1);
    check("abort_addr", 32'(bus.MEM_ADDRESS), 32'd0);
    bus.CPU_REQ = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    RSTb = 1'b1;
    cpu_shadow = '0; dma_shadow = '0;
    cnt_a = 0; cnt_b = 0;
    repeat (8) begin
      @(posedge CLK); #1;
      if (bus.CPU_READY || bus.DMA_READY) cnt_a++;
      if (bus.MEM_WRb == 1'b0 || cur_sel() != 9'd0) cnt_b++;
    end
    check("abort_no_ready", 32'(cnt_a), 32'd0);
    check("abort_no_activity", 32'(cnt_b), 32'd0);
    $display("txn reset-abort CPU RD addr=8000 late_ready=%0d activity=%0d", cnt_a, cnt_b);

    // Both masters request OCM together and hold: CPU wins first after reset, then alternate.
    @(negedge CLK);
    bus.CPU_REQ = 1'b1; bus.CPU_ADDRESS = 16'h4000; bus.CPU_WRb = 1'b1;
    bus.DMA_REQ = 1'b1; bus.DMA_ADDRESS = 16'h4001; bus.DMA_WRb = 1'b1;
    nev = 0; k = 0;
    while (nev < 4 && k < 40) begin
      @(posedge CLK); #1;
      k++;
      check("rr_exclusive", 32'(bus.CPU_READY & bus.DMA_READY), 32'd0);
      if (bus.OCM_SEL)
        check("rr_grant_addr", 32'(bus.MEM_ADDRESS), 32'(16'h4000 + 16'(nev % 2)));
      if (bus.CPU_READY || bus.DMA_READY) begin
        check("rr_owner", 32'(bus.DMA_READY), 32'(nev % 2));
        check("rr_cycle", 32'(k), 32'(2 + 3 * nev));
        check("rr_dout", 32'(bus.DMA_READY ? bus.DMA_DATA_OUT : bus.CPU_DATA_OUT), 32'h0C0C);
        $display("txn rr %0d %s at cycle %0d", nev, bus.DMA_READY ? "DMA" : "CPU", k);
        nev++;
      end
    end
    bus.CPU_REQ = 1'b0; bus.DMA_REQ = 1'b0;
    check("rr_count", 32'(nev), 32'd4);
    @(posedge CLK);

    // CPU_REQ held high: a ROM read completes every third cycle.
    @(negedge CLK);
    bus.CPU_REQ = 1'b1; bus.CPU_ADDRESS = 16'h0100; bus.CPU_WRb = 1'b1;
    nev = 0; k = 0;
    while (nev < 4 && k < 20) begin
      @(posedge CLK); #1;
      k++;
      if (bus.CPU_READY) begin
        check("b2b_cycle", 32'(k), 32'(2 + 3 * nev));
        check("b2b_dout", 32'(bus.CPU_DATA_OUT), 32'hBEEF);
        $display("txn b2b %0d CPU RD addr=0100 at cycle %0d", nev, k);
        nev++;
      end
    end
    bus.CPU_REQ = 1'b0;
    check("b2b_count", 32'(nev), 32'd4);
    repeat (3) @(posedge CLK);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Parametrised next-generation memory controller: two bus masters (CPU, DMA) share one registered slave bus.
- Decodes the system address map into region selects: ROM, NUM_PERIPH peripheral slots, OCM, HIRAM.
- Inserts per-region wait states and returns read data with a READY handshake.
- Sits between the CPU/DMAC and the ROM, RAMs and peripherals; replaces the combinational decoder.

Parameters:
- BITS, 16, data width.
- ADDRESS_BITS, 16, address width (the address map below is defined for 16).
- NUM_PERIPH, 6, peripheral slots at 0x1000 + n*0x100, n = 0..NUM_PERIPH-1 (max 16).
- ROM_WAIT, 0, extra wait cycles for ROM access (0..15).
- PERIPH_WAIT, 1, extra wait cycles for peripheral access (0..15).
- OCM_WAIT, 0, extra wait cycles for OCM access (0..15).
- HIRAM_WAIT, 0, extra wait cycles for HIRAM access (0..15).

Ports:
- CLK  in  1  system clock; all state on rising edge.
- RSTb  in  1  asynchronous active-low reset.
- CPU_REQ  in  1  CPU request; held until CPU_READY.
- CPU_ADDRESS  in  ADDRESS_BITS  CPU address.
- CPU_DATA_IN  in  BITS  CPU write data.
- CPU_WRb  in  1  0 = write, 1 = read.
- CPU_DATA_OUT  out  BITS  registered CPU read data.
- CPU_READY  out  1  one-cycle completion pulse.
- CPU_ERR  out  1  one-cycle error pulse, coincident with CPU_READY.
- DMA_REQ, DMA_ADDRESS, DMA_DATA_IN, DMA_WRb, DMA_DATA_OUT, DMA_READY, DMA_ERR: same as the CPU set, for the DMA master.
- MEM_ADDRESS  out  ADDRESS_BITS  registered slave address.
- MEM_DATA_OUT  out  BITS  registered slave write data.
- MEM_WRb  out  1  slave write strobe, active low.
- ROM_SEL, OCM_SEL, HIRAM_SEL  out  1 each  region selects.
- PERIPH_SEL  out  NUM_PERIPH  one-hot peripheral select.
- ROM_DATA, OCM_DATA, HIRAM_DATA  in  BITS each  slave read data.
- PERIPH_DATA  in  NUM_PERIPH*BITS  slot n occupies bits [n*BITS +: BITS].

Behaviour:
- Reset (async, RSTb low):
  - state = IDLE.
  - All selects 0; MEM_WRb = 1; MEM_ADDRESS and MEM_DATA_OUT = 0.
  - *_READY and *_ERR = 0; *_DATA_OUT = 0.
  - Last-grant pointer = DMA, so the CPU wins the first contention.
  - Reset mid-transaction aborts it: no READY, no write.
- Decode (from the latched address):
  - 0x0000-0x0FFF -> ROM.
  - 0x1n00-0x1nFF with n < NUM_PERIPH -> PERIPH_SEL[n].
  - 0x4000-0x7FFF -> OCM.
  - 0x8000-0xFFFF -> HIRAM.
  - Anything else is unmapped.
  - DMA access to any region other than OCM is treated as unmapped.
- State machine: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - If any REQ is high: grant it and latch address, data, WRb, region and master.
  - Load the wait counter with the region's WAIT value (0 if unmapped); go to ACCESS.
  - If both REQs are high, grant the master not granted last (round robin), then update the pointer.
- ACCESS:
  - Selected region's select held high every cycle; no select if unmapped.
  - Counter decrements each cycle while nonzero.
  - In the cycle with counter == 0:
    - MEM_WRb = latched WRb (single-cycle write strobe); writes to unmapped addresses are suppressed.
    - Read data from the selected slave (0 if unmapped) is registered into the granted master's DATA_OUT at the clock edge.
  - Then go to DONE.
- DONE:
  - Selects 0 and MEM_WRb = 1.
  - Granted master's READY = 1 for exactly this cycle; ERR = 1 if unmapped.
  - Next state is IDLE.
- Latency:
  - REQ sampled in IDLE at cycle N -> READY at cycle N + 2 + WAIT.
  - A REQ still high during DONE is a new request, sampled in the following IDLE cycle.
  - Peak throughput is one access per 3 + WAIT cycles.
- Non-granted master:
  - Its DATA_OUT holds its last value; its READY and ERR stay 0.
  - Its REQ remains pending and is not lost.
- Master request changes during ACCESS are ignored, because address and data are latched.
- DATA_OUT holds its value until that master's next read completes. Writes leave DATA_OUT unchanged.

Test Plan:
- Reset, then CPU read 0x0005 with ROM_DATA = 0xBEEF, ROM_WAIT = 0 -> ROM_SEL high 1 cycle, CPU_READY at N+2, CPU_DATA_OUT = 0xBEEF, CPU_ERR = 0.
- CPU write 0x1000 with data 0x0041, PERIPH_WAIT = 1 -> PERIPH_SEL = 6'b000001 for 2 cycles, MEM_WRb low only in the 2nd, MEM_DATA_OUT = 0x0041, CPU_READY at N+3.
- CPU_REQ and DMA_REQ raised together, both to OCM 0x4000/0x4001, held through two rounds -> grants CPU, DMA, CPU, DMA; each READY pulses only for its owner.
- DMA read 0x8000 -> no select asserted, DMA_READY and DMA_ERR both pulse, DMA_DATA_OUT = 0x0000; CPU read 0x2000 -> CPU_ERR pulse, no MEM_WRb strobe.
- CPU read of HIRAM with HIRAM_WAIT = 3 and RSTb pulsed low during ACCESS -> selects drop immediately, no CPU_READY; the next request after reset completes normally.
- CPU_REQ held high continuously for 0x8000 reads -> CPU_READY pulses every 3 cycles with HIRAM_WAIT = 0.
